fir_response_monitor: RTL and testbench

Synthesizable capture/measurement block on the output side of the FIR filters (`FIR_symmetric`, `FIR_adderTree`). It watches `output_signal_y` after a `start` pulse and measures the filter's response:
- latency to the first significant sample
- peak sample and its index
- last captured sample
- signed sum over a capture window

It is the on-chip counterpart of the bench stimulus driver, letting impulse, step and signal tests be scored in hardware.

---
 rtl/fir_response_monitor.sv | 185 ++++++++++++++++++
 tb/tb_fir_response_monitor.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_response_monitor.sv
// fir_response_monitor: watches the FIR output after a start pulse and
// measures trigger latency, peak sample and index, last sample and the
// signed sum of a capture window. Results are held in DONE until the next
// start or reset.
module fir_response_monitor #(
    parameter int width = 16,
    parameter int CNT_W = 16,
    parameter int ACC_W = width + CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [width-1:0] output_signal_y,
    input  logic [width-2:0]        threshold,
    input  logic [CNT_W-1:0]        capture_len,
    input  logic [CNT_W-1:0]        max_wait,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [CNT_W-1:0]        latency,
    output logic signed [width-1:0] peak_value,
    output logic [CNT_W-1:0]        peak_index,
    output logic signed [width-1:0] last_value,
    output logic signed [ACC_W-1:0] accum
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    // Settings captured on the start edge so the inputs may change freely
    // while a measurement runs.
    logic [width-2:0]        thr_q;
    logic [CNT_W-1:0]        last_idx_q;
    logic [CNT_W-1:0]        max_wait_q;

    // cnt counts WAIT edges, then is reused as the capture index.
    logic [CNT_W-1:0]        cnt;

    // Magnitude of the running peak, kept alongside peak_value so the
    // comparison does not need a second absolute-value circuit.
    logic [width:0]          peak_mag;

    logic [width:0]          y_ext;
    logic [width:0]          y_mag;
    logic signed [ACC_W-1:0] y_sext;
    logic                    triggered;
    logic                    wait_expired;
    logic                    capture_last;
    logic                    trigger_last;

    // Sample magnitude in width+1 bits so the most negative value maps to
    // 2^(width-1) without saturation, plus the derived decision flags.
    always_comb begin
        y_ext        = {output_signal_y[width-1], output_signal_y};
        y_mag        = y_ext[width] ? (~y_ext + 1'b1) : y_ext;
        y_sext       = {{(ACC_W-width){output_signal_y[width-1]}}, output_signal_y};
        triggered    = (y_mag > {2'b00, thr_q});
        // cnt+1 >= max_wait also covers max_wait = 0 timing out on the first edge
        wait_expired = (({1'b0, cnt} + (CNT_W+1)'(1)) >= {1'b0, max_wait_q});
        capture_last = (cnt == last_idx_q);
        trigger_last = (last_idx_q == '0);
    end

    // State register; reset drops straight back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start wins over every other transition so a
    // running measurement can be aborted and re-armed.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = S_WAIT;
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_IDLE;
                end
                S_WAIT: begin
                    if (triggered) begin
                        state_next = trigger_last ? S_DONE : S_CAPTURE;
                    end else if (wait_expired) begin
                        state_next = S_DONE;
                    end
                end
                S_CAPTURE: begin
                    if (capture_last) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    state_next = S_DONE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // busy and done are decoded purely from the state register, so they
    // have no combinational path from any input.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_WAIT:    busy = 1'b1;
            S_CAPTURE: busy = 1'b1;
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

    // Statistics datapath: cleared and re-armed on start, counts WAIT edges,
    // and folds each capture sample into sum, peak and last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thr_q      <= '0;
            last_idx_q <= '0;
            max_wait_q <= '0;
            cnt        <= '0;
            timeout    <= 1'b0;
            latency    <= '0;
            peak_value <= '0;
            peak_mag   <= '0;
            peak_index <= '0;
            last_value <= '0;
            accum      <= '0;
        end else if (start) begin
            thr_q      <= threshold;
            last_idx_q <= (capture_len == '0) ? '0 : (capture_len - 1'b1);
            max_wait_q <= max_wait;
            cnt        <= '0;
            timeout    <= 1'b0;
            latency    <= '0;
            peak_value <= '0;
            peak_mag   <= '0;
            peak_index <= '0;
            last_value <= '0;
            accum      <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (triggered) begin
                        // The trigger sample is capture index 0 and always seeds the peak.
                        latency    <= cnt;
                        accum      <= accum + y_sext;
                        peak_value <= output_signal_y;
                        peak_mag   <= y_mag;
                        peak_index <= '0;
                        last_value <= output_signal_y;
                        cnt        <= CNT_W'(1);
                    end else if (wait_expired) begin
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    accum      <= accum + y_sext;
                    last_value <= output_signal_y;
                    if (y_mag > peak_mag) begin
                        peak_value <= output_signal_y;
                        peak_mag   <= y_mag;
                        peak_index <= cnt;
                    end
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_response_monitor.sv
// Testbench for fir_response_monitor: fixed test vectors, hand-written
// reset/restart sequences and randomized runs scored against a
// window-based reference model.
module tb_fir_response_monitor;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] output_signal_y;
    logic [14:0]        threshold;
    logic [15:0]        capture_len;
    logic [15:0]        max_wait;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [15:0]        latency;
    logic signed [15:0] peak_value;
    logic [15:0]        peak_index;
    logic signed [15:0] last_value;
    logic signed [31:0] accum;

    int testsRun    = 0;
    int testsFailed = 0;

    // Sample stream fed to the DUT, one entry per edge after start.
    int stimY [0:299];

    typedef struct {
        int     thr;
        int     len;
        int     mw;
        int     ys [12];
        int     fill;
        int     eDone;
        int     eTimeout;
        int     eLat;
        int     ePeak;
        int     ePeakIdx;
        int     eLast;
        longint eAccum;
    } vec_t;

    typedef struct {
        int     done_edge;
        int     timeout;
        int     latency;
        int     peak;
        int     peak_idx;
        int     last;
        longint accum;
    } exp_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    fir_response_monitor dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .output_signal_y (output_signal_y),
        .threshold       (threshold),
        .capture_len     (capture_len),
        .max_wait        (max_wait),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .latency         (latency),
        .peak_value      (peak_value),
        .peak_index      (peak_index),
        .last_value      (last_value),
        .accum           (accum)
    );

    // Global time limit so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int absInt(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: find the first sample above threshold inside the allowed
    // wait window, then summarize the following capture window.
    function automatic exp_t model(input int thr, input int len, input int mw);
        exp_t r;
        int   n;
        int   w;
        int   k;
        longint sum;
        n = (len == 0) ? 1 : len;
        w = (mw == 0) ? 1 : mw;
        r = '{default: 0};
        k = -1;
        for (int e = 0; e < w; e++) begin
            if (absInt(stimY[e]) > thr) begin
                k = e;
                break;
            end
        end
        if (k < 0) begin
            r.timeout   = 1;
            r.done_edge = w;
            return r;
        end
        r.latency   = k;
        r.done_edge = k + n;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            int v;
            v = stimY[k + i];
            sum = sum + v;
            if (i == 0 || absInt(v) > absInt(r.peak)) begin
                r.peak     = v;
                r.peak_idx = i;
            end
            r.last = v;
        end
        r.accum = sum;
        return r;
    endfunction

    task automatic setVec(input int idx, input int thr, input int len, input int mw, input int fill,
                          input int eDone, input int eTimeout, input int eLat, input int ePeak,
                          input int ePeakIdx, input int eLast, input longint eAccum);
        vecs[idx].thr      = thr;
        vecs[idx].len      = len;
        vecs[idx].mw       = mw;
        vecs[idx].fill     = fill;
        vecs[idx].eDone    = eDone;
        vecs[idx].eTimeout = eTimeout;
        vecs[idx].eLat     = eLat;
        vecs[idx].ePeak    = ePeak;
        vecs[idx].ePeakIdx = ePeakIdx;
        vecs[idx].eLast    = eLast;
        vecs[idx].eAccum   = eAccum;
    endtask

    // Pulse start, then drive stimY one sample per edge until done rises.
    // Settings are scrambled after the start edge to show they were latched.
    task automatic applyStimulus(input int thr, input int len, input int mw,
                                 output int doneEdge, output bit busyOk,
                                 output bit clearOk, output bit heldOk);
        logic [15:0]        junk;
        logic signed [31:0] savedAccum;
        logic signed [15:0] savedLast;
        @(negedge clk);
        start           = 1'b1;
        threshold       = 15'(thr);
        capture_len     = 16'(len);
        max_wait        = 16'(mw);
        junk            = 16'($urandom);
        output_signal_y = junk;
        @(posedge clk);
        #1;
        busyOk  = (busy === 1'b1) && (done === 1'b0);
        clearOk = (accum == 0) && (latency == 0) && (timeout == 1'b0) &&
                  (peak_value == 0) && (peak_index == 0) && (last_value == 0);
        doneEdge = -1;
        for (int e = 1; e <= 400; e++) begin
            @(negedge clk);
            start = 1'b0;
            if (e == 1) begin
                threshold   = 15'($urandom);
                capture_len = 16'($urandom);
                max_wait    = 16'($urandom);
            end
            output_signal_y = (e - 1 < 300) ? 16'(stimY[e-1]) : 16'd0;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                doneEdge = e;
                break;
            end
            if (busy !== 1'b1) busyOk = 1'b0;
        end
        heldOk = (doneEdge > 0);
        savedAccum = accum;
        savedLast  = last_value;
        for (int e = 0; e < 2; e++) begin
            @(negedge clk);
            junk            = 16'($urandom);
            output_signal_y = junk;
            @(posedge clk);
            #1;
            if (done !== 1'b1 || busy !== 1'b0 || accum != savedAccum || last_value != savedLast)
                heldOk = 1'b0;
        end
    endtask

    task automatic checkRun(input string tag, input exp_t x, input int doneEdge,
                            input bit busyOk, input bit clearOk, input bit heldOk);
        checkOutput({tag, "_doneEdge"},  doneEdge, x.done_edge);
        checkOutput({tag, "_timeout"},   longint'(timeout), x.timeout);
        checkOutput({tag, "_latency"},   longint'(latency), x.latency);
        checkOutput({tag, "_peakValue"}, longint'($signed(peak_value)), x.peak);
        checkOutput({tag, "_peakIndex"}, longint'(peak_index), x.peak_idx);
        checkOutput({tag, "_lastValue"}, longint'($signed(last_value)), x.last);
        checkOutput({tag, "_accum"},     longint'($unsigned(accum)), x.accum & 64'hFFFF_FFFF);
        checkOutput({tag, "_busy"},      longint'(busyOk), 1);
        checkOutput({tag, "_cleared"},   longint'(clearOk), 1);
        checkOutput({tag, "_held"},      longint'(heldOk), 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},      longint'(busy), 0);
        checkOutput({tag, "_done"},      longint'(done), 0);
        checkOutput({tag, "_timeout"},   longint'(timeout), 0);
        checkOutput({tag, "_latency"},   longint'(latency), 0);
        checkOutput({tag, "_peakValue"}, longint'($signed(peak_value)), 0);
        checkOutput({tag, "_peakIndex"}, longint'(peak_index), 0);
        checkOutput({tag, "_lastValue"}, longint'($signed(last_value)), 0);
        checkOutput({tag, "_accum"},     longint'($unsigned(accum)), 0);
    endtask

    initial begin
        exp_t        x;
        int          doneEdge;
        bit          busyOk;
        bit          clearOk;
        bit          heldOk;
        int          thr;
        int          len;
        int          mw;
        logic [15:0] r16;

        reset           = 1'b1;
        start           = 1'b0;
        output_signal_y = '0;
        threshold       = '0;
        capture_len     = '0;
        max_wait        = '0;

        // Test vectors: thr, len, max_wait, fill, doneEdge, timeout, latency, peak, peakIdx, last, accum
        setVec(0, 50,   4, 100,     0,   9, 0, 5,   -500, 2,   200,     100);
        vecs[0].ys = '{0, 0, 0, 0, 0, 100, 300, -500, 200, 0, 0, 0};
        setVec(1, 50,   4,  10,     0,  10, 1, 0,      0, 0,     0,       0);
        vecs[1].ys = '{default: 0};
        setVec(2,  0,   3, 100,     0,   3, 0, 0, -32768, 1, 32767,   32766);
        vecs[2].ys = '{32767, -32768, 32767, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        setVec(3, 100,  2, 100,     0,   2, 0, 0,    400, 0,  -400,       0);
        vecs[3].ys = '{400, -400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        setVec(4, 10,   0, 100,     0,   3, 0, 2,     77, 0,    77,      77);
        vecs[4].ys = '{0, 0, 77, 5, 0, 0, 0, 0, 0, 0, 0, 0};
        setVec(5,  0, 256, 100, 32767, 256, 0, 0,  32767, 0, 32767, 8388352);
        vecs[5].ys = '{default: 32767};
        setVec(6, 50,   4,   0,     0,   1, 1, 0,      0, 0,     0,       0);
        vecs[6].ys = '{default: 0};
        setVec(7, 50,   1,   3,     0,   3, 0, 2,    -60, 0,   -60,     -60);
        vecs[7].ys = '{0, 0, -60, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        setVec(8, 100,  1,  10,     0,   3, 0, 2,   -101, 0,  -101,    -101);
        vecs[8].ys = '{100, -100, -101, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset state
        #12;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_after_reset_busy", longint'(busy), 0);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 300; j++) stimY[j] = (j < 12) ? vecs[i].ys[j] : vecs[i].fill;
            applyStimulus(vecs[i].thr, vecs[i].len, vecs[i].mw, doneEdge, busyOk, clearOk, heldOk);
            x.done_edge = vecs[i].eDone;
            x.timeout   = vecs[i].eTimeout;
            x.latency   = vecs[i].eLat;
            x.peak      = vecs[i].ePeak;
            x.peak_idx  = vecs[i].ePeakIdx;
            x.last      = vecs[i].eLast;
            x.accum     = vecs[i].eAccum;
            checkRun($sformatf("vec%0d", i), x, doneEdge, busyOk, clearOk, heldOk);
        end

        // Asynchronous reset in the middle of a capture
        @(negedge clk);
        start = 1'b1; threshold = 15'd0; capture_len = 16'd50; max_wait = 16'd5;
        @(posedge clk);
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            start = 1'b0;
            output_signal_y = 16'sd1000;
            @(posedge clk);
        end
        #1;
        checkOutput("midcap_accum", longint'($unsigned(accum)), 4000);
        checkOutput("midcap_busy",  longint'(busy), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkAllZero("async_reset");
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_idle_busy", longint'(busy), 0);
        checkOutput("post_reset_idle_done", longint'(done), 0);

        // Restart with start while a capture is running
        @(negedge clk);
        start = 1'b1; threshold = 15'd0; capture_len = 16'd20; max_wait = 16'd50;
        @(posedge clk);
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            start = 1'b0;
            output_signal_y = 16'sd500;
            @(posedge clk);
        end
        #1;
        checkOutput("restart_precap_accum", longint'($unsigned(accum)), 1500);
        for (int j = 0; j < 300; j++) stimY[j] = 0;
        stimY[3] = 300;
        stimY[4] = -700;
        applyStimulus(100, 2, 50, doneEdge, busyOk, clearOk, heldOk);
        x = model(100, 2, 50);
        checkRun("restart", x, doneEdge, busyOk, clearOk, heldOk);

        // Randomized runs against the reference model
        for (int i = 0; i < 40; i++) begin
            thr = ($urandom_range(0, 4) == 0) ? 32767 : int'($urandom_range(0, 2000));
            len = int'($urandom_range(0, 12));
            mw  = int'($urandom_range(0, 15));
            for (int j = 0; j < 300; j++) begin
                case ($urandom_range(0, 7))
                    0, 1: begin
                        r16 = 16'($urandom);
                        stimY[j] = int'($signed(r16));
                    end
                    2:       stimY[j] = -32768;
                    default: stimY[j] = int'($urandom_range(0, 2 * thr)) - thr;
                endcase
            end
            applyStimulus(thr, len, mw, doneEdge, busyOk, clearOk, heldOk);
            x = model(thr, len, mw);
            checkRun($sformatf("rand%0d", i), x, doneEdge, busyOk, clearOk, heldOk);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
